// File: rtl/ring_ctr_rotator_if.sv
// Bus bundle for the ring counter: direction and seed in, ring state out.
// There is no handshake here. The master drives mode and init every cycle.
// The slave returns the registered ring state on count.
interface ring_ctr_rotator_if #(
  parameter int WIDTH = 8
);
  logic             mode;
  logic [WIDTH-1:0] init;
  logic [WIDTH-1:0] count;

  modport master (
    output mode,
    output init,
    input  count
  );

  modport slave (
    input  mode,
    input  init,
    output count
  );
endinterface

// File: rtl/ring_ctr_rotator.sv
// Bidirectional ring counter with a loadable seed.
// Reset loads init, or 1 in the LSB when init is zero, so the ring never sticks
// at all-zeros. Outside reset the pattern rotates one bit per clock. mode=1
// rotates toward the MSB and mode=0 rotates toward the LSB.
module ring_ctr_rotator #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  ring_ctr_rotator_if.slave   bus
);

  localparam logic [WIDTH-1:0] ONE_HOT_SEED = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] ring;

  // Ring register: seed load while rst is high, otherwise a single-bit rotate.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (bus.init != '0) begin
        ring <= bus.init;
      end else begin
        ring <= ONE_HOT_SEED;
      end
    end else if (bus.mode) begin
      ring <= {ring[WIDTH-2:0], ring[WIDTH-1]};
    end else begin
      ring <= {ring[0], ring[WIDTH-1:1]};
    end
  end

  assign bus.count = ring;

endmodule

// File: tb/tb_ring_ctr_rotator.sv
// Self-checking bench for ring_ctr_rotator (WIDTH=8).
// Each step pushes the expected ring value when the inputs are driven.
// After the clock edge the value is popped and compared.
module tb_ring_ctr_rotator;

  localparam int W = 8;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  ring_ctr_rotator_if #(.WIDTH(W)) bus ();

  ring_ctr_rotator #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Single comparison point.
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare after the edge.
  task automatic step(input logic r, input logic m, input logic [W-1:0] i,
                      input logic [W-1:0] e, input string tag);
    logic [W-1:0] want;
    @(negedge clk);
    rst      = r;
    bus.mode = m;
    bus.init = i;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got empty queue, expected entry", tag);
    end else begin
      want = exp_q.pop_front();
      check(tag, bus.count, want);
    end
  endtask

  // Reference rotate that walks the bits one at a time.
  function automatic logic [W-1:0] model_rot(input logic [W-1:0] v, input logic left);
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) begin
      if (left) r[(b + 1) % W] = v[b];
      else      r[(b + W - 1) % W] = v[b];
    end
    return r;
  endfunction

  logic [7:0] left_seq  [8] = '{8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81, 8'h03};
  logic [7:0] right_seq [8] = '{8'h81, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03};

  initial begin
    logic [W-1:0] model;
    logic [W-1:0] seed;
    logic [W-1:0] ri;
    logic         rr, rm;
    int           pc;
    int           since_rst;

    rst      = 1'b1;
    bus.mode = 1'b0;
    bus.init = 8'h03;

    // Seed load, then a full left period.
    step(1, 0, 8'h03, 8'h03, "seed_load");
    for (int k = 0; k < 8; k++) step(0, 1, 8'h03, left_seq[k], "rot_left");

    // Full right period from the same seed.
    step(1, 1, 8'h03, 8'h03, "seed_right");
    for (int k = 0; k < 8; k++) step(0, 0, 8'h03, right_seq[k], "rot_right");

    // Direction switch in the middle of a run.
    step(1, 0, 8'h03, 8'h03, "seed_switch");
    step(0, 1, 8'h03, 8'h06, "switch_l1");
    step(0, 1, 8'h03, 8'h0C, "switch_l2");
    step(0, 0, 8'h03, 8'h06, "switch_r1");
    step(0, 0, 8'h03, 8'h03, "switch_r2");
    step(0, 0, 8'h03, 8'h81, "switch_r3");

    // Zero-seed reset mid-rotation. A changing init while rst is low is ignored.
    step(1, 1, 8'h00, 8'h01, "zero_seed");
    step(0, 1, 8'hFF, 8'h02, "post_zero_1");
    step(0, 1, 8'h5A, 8'h04, "post_zero_2");
    step(0, 1, 8'h00, 8'h08, "init_ignored");

    // Held reset reloads init on every edge.
    step(1, 1, 8'h11, 8'h11, "hold_rst_1");
    step(1, 0, 8'hA5, 8'hA5, "hold_rst_2");
    step(1, 1, 8'h80, 8'h80, "hold_rst_3");
    step(0, 0, 8'h80, 8'h40, "hold_release");

    // Random phase: occasional resets, random direction, popcount and period checks.
    seed      = 8'h01;
    model     = 8'h40;
    pc        = 1;
    since_rst = 0;
    for (int n = 0; n < 200; n++) begin
      rr = ($urandom_range(0, 9) == 0);
      rm = 1'($urandom_range(0, 1));
      ri = 8'($urandom_range(0, 255));
      if (n % 37 == 0) ri = 8'h00;
      if (rr) begin
        model     = (ri != 0) ? ri : 8'h01;
        seed      = model;
        pc        = $countones(model);
        since_rst = 0;
      end else begin
        model = model_rot(model, rm);
        since_rst++;
      end
      step(rr, rm, ri, model, "rand");
      if (!rr) begin
        n_checks++;
        if ($countones(bus.count) != pc) begin
          n_fail++;
          $display("FAIL popcount: got %0d expected %0d", $countones(bus.count), pc);
        end
      end
    end

    // Period check: a right rotation by W steps returns the seed.
    step(1, 0, 8'h2D, 8'h2D, "period_seed");
    for (int k = 0; k < W - 1; k++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.mode = 1'b0;
      @(posedge clk);
    end
    step(0, 0, 8'h00, 8'h2D, "period_right");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
